pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Multi-cycle PC controller that owns the architectural PC register and sequences the fetch, execute and update phases of each instruction. It drives the source and offset selects of the shared `pc_generator` adder and resolves branch conditions from the ALU flags. It commits the adder's `next_pc` result once per instruction. It sits between the control decoder, instruction memory handshake and the PC datapath.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `TRAP_PC`, 32'h0000_1000: redirect target for misaligned next PC. Used only when `PC_MISALIGN_TRAP_EN` is defined.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `stall`  in  1  freezes the FSM and all registers while high.
- `fetch_req`  out  1  instruction fetch request for address `pc`.
- `fetch_ack`  in  1  instruction memory has accepted or returned the fetch.
- `exec_done`  in  1  datapath finished execute; `branch`, `zero` and `less` are valid.
- `branch`  in  3  branch type: 000 none, 001 jal, 010 jalr, 100 beq, 101 bne, 110 blt, 111 bge. 011 is treated as none.
- `zero`, `less`  in  1 each  ALU flags.
- `next_pc`  in  32  result from `pc_generator`.
- `pc`  out  32  current PC register.
- `PCAsrc`, `PCBsrc`  out  1 each  offset select (imm/4) and source select (Ra/pc) to `pc_generator`.
- `retire`  out  1  one-cycle pulse when the PC commits.
- `misalign`  out  1  one-cycle pulse on misaligned target (trap build only; otherwise tied 0).

## Operation
- FSM states and transitions:
  - IDLE → FETCH unconditionally.
  - FETCH: `fetch_req`=1 while not stalled; `fetch_ack` → EXEC.
  - EXEC: `exec_done` → UPDATE, registering the select decision.
  - UPDATE: `pc` ← `next_pc`, `retire`=1, → FETCH.
- Select decision, sampled on `exec_done`:
  - jal: A=1, B=0.
  - jalr: A=1, B=1.
  - beq: A=`zero`. bne: A=~`zero`. blt: A=`less`. bge: A=~`less`. B=0 for all four.
  - none: A=0, B=0.
- `PCAsrc`/`PCBsrc` are registered. They hold the decision during UPDATE only and are 0 in every other state, so the adder computes pc+4.
- `stall` high: state, `pc` and selects are held; `fetch_req` is forced 0; `fetch_ack`/`exec_done` are ignored; `retire` is suppressed.
- `fetch_ack` outside FETCH and `exec_done` outside EXEC are ignored.
- Flags are sampled only on the `exec_done` cycle; later changes have no effect.

## Timing
- Reset values: state IDLE, `pc`=`RESET_PC`, `fetch_req`=0, `PCAsrc`=0, `PCBsrc`=0, `retire`=0, `misalign`=0.
- First `fetch_req` appears 1 cycle after reset release.
- `fetch_ack` is accepted in the same cycle `fetch_req` is high. Minimum 3 cycles per instruction (FETCH, EXEC, UPDATE) with immediate ack and done.
- `pc` takes its new value on the UPDATE→FETCH edge. `retire` is high during the UPDATE cycle.
- `next_pc` wraps modulo 2^32 with no overflow indication.
- Reset asserted mid-instruction aborts immediately with no `retire`. `fetch_req` drops asynchronously.

## Configuration
- `PC_MISALIGN_TRAP_EN` defined: if `next_pc[1:0]`≠0 in UPDATE, `pc` ← `TRAP_PC` and `misalign` pulses together with `retire`.
- `PC_MISALIGN_TRAP_EN` undefined: `pc` ← {`next_pc[31:2]`, 2'b00}; `misalign` is constant 0.

## Structure
- Shared package `cpu_pkg` holds:
  - `branch_t` enum with the codes above.
  - `pc_state_t` enum (IDLE, FETCH, EXEC, UPDATE).
  - `RESET_PC`/`TRAP_PC` default constants.
- Natural sub-module: `branch_resolver`, combinational mapping of `branch`, `zero` and `less` to {A, B}. The FSM instantiates it.

## Test plan
- Reset release, ack/done immediate, branch=000, `next_pc`=pc+4 → `pc` 0→4→8, `retire` every 3rd cycle.
- beq with `zero`=1, then `zero`=0 → `PCAsrc`=1 then 0 in UPDATE, `PCBsrc`=0 both times.
- jalr, `next_pc`=32'h0000_0102 → with macro: `pc`=`TRAP_PC`, `misalign`=1. Without: `pc`=32'h0000_0100.
- `stall` held 5 cycles during FETCH → `fetch_req`=0, `fetch_ack` ignored, `pc` unchanged, then resumes.
- `rst` pulsed during EXEC after pc=32'h40 → `pc`=`RESET_PC`, state IDLE, no `retire`.
- blt/bge with `less`=1, `less` toggled after `exec_done` → `PCAsrc` reflects the sampled value (1 for blt, 0 for bge).

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU control types: branch encodings, PC sequencer states and PC constants.
package cpu_pkg;

    typedef enum logic [2:0] {
        BR_NONE = 3'b000,
        BR_JAL  = 3'b001,
        BR_JALR = 3'b010,
        BR_RSVD = 3'b011,
        BR_BEQ  = 3'b100,
        BR_BNE  = 3'b101,
        BR_BLT  = 3'b110,
        BR_BGE  = 3'b111
    } branch_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_EXEC   = 2'd2,
        ST_UPDATE = 2'd3
    } pc_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] TRAP_PC_DEFAULT  = 32'h0000_1000;

endpackage

// File: rtl/branch_resolver.sv
// Maps branch type and ALU flags to the pc_generator selects {A = imm/4, B = Ra/pc}.
module branch_resolver
    import cpu_pkg::*;
(
    input  logic [2:0] i_branch,
    input  logic       i_zero,
    input  logic       i_less,
    output logic       o_a,
    output logic       o_b
);

    always_comb begin
        o_a = 1'b0;
        o_b = 1'b0;
        case (branch_t'(i_branch))
            BR_JAL:  o_a = 1'b1;
            BR_JALR: begin
                o_a = 1'b1;
                o_b = 1'b1;
            end
            BR_BEQ:  o_a = i_zero;
            BR_BNE:  o_a = ~i_zero;
            BR_BLT:  o_a = i_less;
            BR_BGE:  o_a = ~i_less;
            default: o_a = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle PC controller: IDLE -> FETCH -> EXEC -> UPDATE, commits next_pc once per instruction.
// Optional misaligned-target trap enabled by defining PC_MISALIGN_TRAP_EN.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
`ifdef PC_MISALIGN_TRAP_EN
    ,
    parameter logic [31:0] TRAP_PC  = TRAP_PC_DEFAULT
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    output logic        fetch_req,
    input  logic        fetch_ack,
    input  logic        exec_done,
    input  logic [2:0]  branch,
    input  logic        zero,
    input  logic        less,
    input  logic [31:0] next_pc,
    output logic [31:0] pc,
    output logic        PCAsrc,
    output logic        PCBsrc,
    output logic        retire,
    output logic        misalign,
    output pc_state_t   o_state
);

    pc_state_t   r_state;
    pc_state_t   w_next_state;
    logic [31:0] r_pc;
    logic        r_a;
    logic        r_b;
    logic        w_a;
    logic        w_b;
    logic [31:0] w_commit_pc;

    branch_resolver u_branch_resolver (
        .i_branch (branch),
        .i_zero   (zero),
        .i_less   (less),
        .o_a      (w_a),
        .o_b      (w_b)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (!stall) begin
            case (r_state)
                ST_IDLE:   w_next_state = ST_FETCH;
                ST_FETCH:  if (fetch_ack) w_next_state = ST_EXEC;
                ST_EXEC:   if (exec_done) w_next_state = ST_UPDATE;
                ST_UPDATE: w_next_state = ST_FETCH;
                default:   w_next_state = ST_IDLE;
            endcase
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    logic w_misaligned;
    assign w_misaligned = (next_pc[1:0] != 2'b00);
    assign w_commit_pc  = w_misaligned ? TRAP_PC : next_pc;
`else
    assign w_commit_pc  = next_pc & ~32'h0000_0003;
`endif

    always_comb begin
        fetch_req = (r_state == ST_FETCH) && !stall;
        retire    = (r_state == ST_UPDATE) && !stall;
`ifdef PC_MISALIGN_TRAP_EN
        misalign  = (r_state == ST_UPDATE) && !stall && w_misaligned;
`else
        misalign  = 1'b0;
`endif
    end

    // Selects are captured on exec_done and cleared when UPDATE commits,
    // so outside UPDATE the adder always sees pc+4.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
            r_a  <= 1'b0;
            r_b  <= 1'b0;
        end else if (!stall) begin
            if (r_state == ST_EXEC && exec_done) begin
                r_a <= w_a;
                r_b <= w_b;
            end else if (r_state == ST_UPDATE) begin
                r_a  <= 1'b0;
                r_b  <= 1'b0;
                r_pc <= w_commit_pc;
            end
        end
    end

    assign pc      = r_pc;
    assign PCAsrc  = r_a;
    assign PCBsrc  = r_b;
    assign o_state = r_state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized instructions
// scored against a behavioural model through an expected-retire queue.
module tb_pc_sequencer;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        fetch_ack;
    logic        exec_done;
    logic [2:0]  branch;
    logic        zero;
    logic        less;
    logic [31:0] next_pc;
    logic        fetch_req;
    logic [31:0] pc;
    logic        PCAsrc;
    logic        PCBsrc;
    logic        retire;
    logic        misalign;
    pc_state_t   o_state;

    localparam logic [31:0] EXP_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] EXP_TRAP_PC  = 32'h0000_1000;
    localparam int W = 67;

    pc_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .fetch_req (fetch_req),
        .fetch_ack (fetch_ack),
        .exec_done (exec_done),
        .branch    (branch),
        .zero      (zero),
        .less      (less),
        .next_pc   (next_pc),
        .pc        (pc),
        .PCAsrc    (PCAsrc),
        .PCBsrc    (PCBsrc),
        .retire    (retire),
        .misalign  (misalign),
        .o_state   (o_state)
    );

    always #5 clk = ~clk;

    // Expected entry: {pc at retire, pc after commit, A, B, misalign}
    logic [W-1:0] exp_q[$];
    int           retire_cyc_q[$];
    int           vec_cnt    = 0;
    int           err_cnt    = 0;
    int           push_cnt   = 0;
    int           retire_cnt = 0;
    int           cyc        = 0;
    logic [31:0]  model_pc;
    logic         pend_valid = 1'b0;
    logic [31:0]  pend_pc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: which adder operands the instruction should select.
    function automatic logic [1:0] ref_sel(input logic [2:0] br, input logic z, input logic l);
        case (br)
            3'b001:  return 2'b10;
            3'b010:  return 2'b11;
            3'b100:  return {z, 1'b0};
            3'b101:  return {!z, 1'b0};
            3'b110:  return {l, 1'b0};
            3'b111:  return {!l, 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    // Reference: committed pc and misalign flag for a given adder result.
    function automatic logic [32:0] ref_commit(input logic [31:0] tgt);
`ifdef PC_MISALIGN_TRAP_EN
        if (tgt % 4 != 0) return {EXP_TRAP_PC, 1'b1};
        return {tgt, 1'b0};
`else
        return {(tgt / 4) * 4, 1'b0};
`endif
    endfunction

    always @(negedge clk) begin
        logic [W-1:0] e;
        if (rst) begin
            pend_valid = 1'b0;
        end else begin
            if (pend_valid) begin
                chk("commit_pc", pc, pend_pc);
                pend_valid = 1'b0;
            end
            if (retire) begin
                retire_cnt++;
                retire_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    vec_cnt++;
                    err_cnt++;
                    $display("FAIL retire_unexpected: got retire=1, expected no retire (t=%0t)", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("retire_pc", pc, e[66:35]);
                    chk("pcasrc", {31'b0, PCAsrc}, {31'b0, e[2]});
                    chk("pcbsrc", {31'b0, PCBsrc}, {31'b0, e[1]});
                    chk("misalign", {31'b0, misalign}, {31'b0, e[0]});
                    pend_pc    = e[34:3];
                    pend_valid = 1'b1;
                end
            end
        end
    end

    task automatic wait_fetch(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (fetch_req === 1'b1) begin
                ok = 1'b1;
                return;
            end
            @(posedge clk);
            #1;
        end
        vec_cnt++;
        err_cnt++;
        $display("FAIL fetch_timeout: got no fetch_req, expected fetch_req within 20 cycles");
    endtask

    // Runs one instruction; called at posedge+1 with the DUT in or entering FETCH.
    task automatic run_instr(input logic [2:0] br, input logic z, input logic l,
                             input logic [31:0] tgt, input int ack_dly, input int done_dly,
                             input int stall_f, input int stall_u, input bit toggle);
        bit          ok;
        logic [1:0]  sel;
        logic [32:0] cm;
        wait_fetch(ok);
        if (!ok) return;
        if (stall_f > 0) begin
            stall     = 1'b1;
            fetch_ack = 1'b1;
            for (int i = 0; i < stall_f; i++) begin
                #1;
                chk("stall_fetch_req", {31'b0, fetch_req}, 32'd0);
                chk("stall_pc", pc, model_pc);
                chk("stall_state", o_state, ST_FETCH);
                @(posedge clk);
            end
            #1;
            stall     = 1'b0;
            fetch_ack = 1'b0;
            #1;
            chk("stall_resume", {31'b0, fetch_req}, 32'd1);
        end
        repeat (ack_dly) begin
            exec_done = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        exec_done = 1'b0;
        fetch_ack = 1'b1;
        @(posedge clk);
        #1;
        repeat (done_dly) begin
            fetch_ack = 1'($urandom_range(0, 1));
            branch    = 3'($urandom_range(0, 7));
            zero      = 1'($urandom_range(0, 1));
            less      = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        fetch_ack = 1'b0;
        branch    = br;
        zero      = z;
        less      = l;
        exec_done = 1'b1;
        sel = ref_sel(br, z, l);
        cm  = ref_commit(tgt);
        exp_q.push_back({model_pc, cm[32:1], sel, cm[0]});
        push_cnt++;
        @(posedge clk);
        #1;
        exec_done = 1'b0;
        next_pc   = tgt;
        if (toggle) begin
            zero   = ~zero;
            less   = ~less;
            branch = 3'($urandom_range(0, 7));
        end
        if (stall_u > 0) begin
            stall = 1'b1;
            for (int i = 0; i < stall_u; i++) begin
                #1;
                chk("stall_retire", {31'b0, retire}, 32'd0);
                chk("stall_hold_a", {31'b0, PCAsrc}, {31'b0, sel[1]});
                chk("stall_state_upd", o_state, ST_UPDATE);
                @(posedge clk);
            end
            #1;
            stall = 1'b0;
        end
        @(posedge clk);
        #1;
        model_pc = cm[32:1];
        next_pc  = model_pc + 32'd4;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          ok;
        logic [2:0]  br;
        logic        z;
        logic        l;
        logic [31:0] tgt;
        logic [1:0]  sel;
        rst       = 1'b1;
        stall     = 1'b0;
        fetch_ack = 1'b0;
        exec_done = 1'b0;
        branch    = 3'b000;
        zero      = 1'b0;
        less      = 1'b0;
        next_pc   = 32'd4;
        model_pc  = EXP_RESET_PC;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_pc", pc, EXP_RESET_PC);
        chk("reset_state", o_state, ST_IDLE);
        chk("reset_fetch_req", {31'b0, fetch_req}, 32'd0);
        chk("reset_pcasrc", {31'b0, PCAsrc}, 32'd0);
        chk("reset_pcbsrc", {31'b0, PCBsrc}, 32'd0);
        chk("reset_retire", {31'b0, retire}, 32'd0);
        chk("reset_misalign", {31'b0, misalign}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("first_fetch_req", {31'b0, fetch_req}, 32'd1);

        // Sequential fetch from reset up to pc = 0x40.
        retire_cyc_q.delete();
        for (int i = 0; i < 16; i++)
            run_instr(3'b000, 1'b0, 1'b0, model_pc + 32'd4, 0, 0, 0, 0, 1'b0);
        chk("seq_pc_40", pc, 32'h0000_0040);
        chk("retire_spacing_0", retire_cyc_q[1] - retire_cyc_q[0], 32'd3);
        chk("retire_spacing_1", retire_cyc_q[2] - retire_cyc_q[1], 32'd3);

        // Reset in the middle of EXEC aborts the instruction without retiring.
        wait_fetch(ok);
        fetch_ack = 1'b1;
        @(posedge clk);
        #1;
        fetch_ack = 1'b0;
        chk("pre_reset_state", o_state, ST_EXEC);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_pc", pc, EXP_RESET_PC);
        chk("abort_state", o_state, ST_IDLE);
        chk("abort_fetch_req", {31'b0, fetch_req}, 32'd0);
        chk("abort_retire", {31'b0, retire}, 32'd0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        model_pc = EXP_RESET_PC;
        run_instr(3'b000, 1'b0, 1'b0, 32'd4, 0, 0, 0, 0, 1'b0);
        chk("after_abort_pc", pc, 32'd4);

        // beq taken then not taken.
        run_instr(3'b100, 1'b1, 1'b0, 32'h0000_0200, 0, 0, 0, 0, 1'b0);
        run_instr(3'b100, 1'b0, 1'b0, model_pc + 32'd4, 1, 1, 0, 0, 1'b0);
        chk("beq_pc", pc, 32'h0000_0204);

        // jalr to a misaligned target.
        run_instr(3'b010, 1'b0, 1'b0, 32'h0000_0102, 0, 0, 0, 0, 1'b0);
`ifdef PC_MISALIGN_TRAP_EN
        chk("jalr_trap_pc", pc, EXP_TRAP_PC);
`else
        chk("jalr_align_pc", pc, 32'h0000_0100);
`endif

        // Five-cycle stall in FETCH, then a stalled UPDATE.
        run_instr(3'b000, 1'b0, 1'b0, model_pc + 32'd4, 0, 0, 5, 0, 1'b0);
        run_instr(3'b001, 1'b0, 1'b0, 32'h0000_0300, 0, 0, 0, 3, 1'b0);

        // Flags toggled after exec_done must not change the captured decision.
        run_instr(3'b110, 1'b0, 1'b1, 32'h0000_0400, 0, 0, 0, 0, 1'b1);
        run_instr(3'b111, 1'b0, 1'b1, model_pc + 32'd4, 0, 0, 0, 0, 1'b1);

        // Adder wrap-around.
        run_instr(3'b001, 1'b0, 1'b0, 32'hFFFF_FFFC, 0, 0, 0, 0, 1'b0);
        run_instr(3'b011, 1'b1, 1'b1, model_pc + 32'd4, 0, 0, 0, 0, 1'b0);
        chk("wrap_pc", pc, 32'h0000_0000);

        for (int n = 0; n < 40; n++) begin
            br  = 3'($urandom_range(0, 7));
            z   = 1'($urandom_range(0, 1));
            l   = 1'($urandom_range(0, 1));
            sel = ref_sel(br, z, l);
            if (sel[1])
                tgt = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            else
                tgt = model_pc + 32'd4;
            run_instr(br, z, l, tgt, $urandom_range(0, 3), $urandom_range(0, 3),
                      ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0,
                      ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0,
                      1'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", exp_q.size(), 32'd0);
        chk("retire_count", retire_cnt, push_cnt);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
